// File: rtl/game_pkg.sv
// Shared types and constants for the frog-crossing game sequencer:
// state encoding, playfield geometry and the BCD score representation.
package game_pkg;

    typedef enum logic [2:0] {
        ST_ATTRACT   = 3'd0,
        ST_PLAY      = 3'd1,
        ST_DYING     = 3'd2,
        ST_RESPAWN   = 3'd3,
        ST_LEVEL_UP  = 3'd4,
        ST_GAME_OVER = 3'd5
    } game_state_t;

    localparam int BLOCKSIZE = 32;
    localparam int GOAL_Y    = 32;
    localparam int SCORE_W   = 16;

    typedef logic [3:0]       bcd_digit_t;
    typedef bcd_digit_t [3:0] bcd_score_t;

    localparam bcd_score_t BCD_MAX = 16'h9999;

    // Ripple a +1 through four BCD digits; 9999 is sticky.
    function automatic bcd_score_t bcd_inc_sat(input bcd_score_t v);
        bcd_score_t r;
        logic       carry;
        r     = v;
        carry = 1'b1;
        if (v != BCD_MAX) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[i] == 4'd9) begin
                        r[i] = 4'd0;
                    end else begin
                        r[i]  = r[i] + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Event/status bundle between game_ctrl and the detection, frog, cars and
// renderer blocks. hi_score exists only when GAME_CTRL_HISCORE_EN is defined.
interface game_ctrl_if;
    logic        frame_tick;
    logic        start_btn;
    logic        frog_hit;
    logic        frog_home;
    logic [2:0]  game_state;
    logic [1:0]  lives;
    logic [2:0]  level;
    logic [15:0] score;
    logic [3:0]  car_speed;
    logic        cars_run;
    logic        frog_respawn;
    logic        frog_enable;
`ifdef GAME_CTRL_HISCORE_EN
    logic [15:0] hi_score;
`endif

    modport master (
        output frame_tick, start_btn, frog_hit, frog_home,
        input  game_state, lives, level, score, car_speed,
        input  cars_run, frog_respawn, frog_enable
`ifdef GAME_CTRL_HISCORE_EN
        , input hi_score
`endif
    );

    modport slave (
        input  frame_tick, start_btn, frog_hit, frog_home,
        output game_state, lives, level, score, car_speed,
        output cars_run, frog_respawn, frog_enable
`ifdef GAME_CTRL_HISCORE_EN
        , output hi_score
`endif
    );
endinterface

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear and saturation at 9999.
module bcd_counter4
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       inc,
    output bcd_score_t value
);

    // NOTE: sequential state is written with <= so every register samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      value <= '0;
        else if (clear) value <= '0;
        else if (inc)   value <= bcd_inc_sat(value);
    end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: state machine, lives, level, BCD score and car pacing.
// Define GAME_CTRL_HISCORE_EN to add the hi_score register and output.
module game_ctrl
    import game_pkg::*;
#(
    parameter int LIVES_INIT   = 3,
    parameter int DEATH_FRAMES = 60,
    parameter int WIN_FRAMES   = 90,
    parameter int MAX_LEVEL    = 7,
    parameter int BASE_SPEED   = 1
) (
    input logic        clk,
    input logic        reset,
    game_ctrl_if.slave bus
);

    localparam logic [6:0] DEATH_LAST = 7'(DEATH_FRAMES - 1);
    localparam logic [6:0] WIN_LAST   = 7'(WIN_FRAMES - 1);
    localparam logic [2:0] LEVEL_TOP  = 3'(MAX_LEVEL);
    localparam logic [1:0] LIVES_LOAD = 2'(LIVES_INIT);

    game_state_t state_q, state_d;
    logic [6:0]  frame_cnt;
    logic        start_q, press;
    logic [1:0]  lives_q;
    logic [2:0]  level_q, level_d;
    logic [3:0]  speed_q;
    logic        respawn_q, respawn_d;
    logic        new_game, score_inc, lives_dec;
    logic        cars_run_d, frog_enable_d;
    bcd_score_t  score;

    assign press = bus.start_btn & ~start_q;

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    always_comb begin
        state_d       = state_q;
        new_game      = 1'b0;
        score_inc     = 1'b0;
        lives_dec     = 1'b0;
        cars_run_d    = 1'b0;
        frog_enable_d = 1'b0;
        unique case (state_q)
            ST_ATTRACT: begin
                cars_run_d = 1'b1;
                if (press) begin
                    state_d  = ST_PLAY;
                    new_game = 1'b1;
                end
            end
            ST_PLAY: begin
                cars_run_d    = 1'b1;
                frog_enable_d = 1'b1;
                if (bus.frog_hit) begin
                    state_d = ST_DYING;
                end else if (bus.frog_home) begin
                    state_d   = ST_LEVEL_UP;
                    score_inc = 1'b1;
                end
            end
            ST_DYING: begin
                if (bus.frame_tick && frame_cnt == DEATH_LAST) begin
                    lives_dec = 1'b1;
                    state_d   = (lives_q == 2'd1) ? ST_GAME_OVER : ST_RESPAWN;
                end
            end
            ST_LEVEL_UP: begin
                if (bus.frame_tick && frame_cnt == WIN_LAST) state_d = ST_RESPAWN;
            end
            ST_RESPAWN:   state_d = ST_PLAY;
            ST_GAME_OVER: if (press) state_d = ST_ATTRACT;
            default:      state_d = ST_ATTRACT;
        endcase
    end

    always_comb begin
        level_d = level_q;
        if (new_game)                             level_d = '0;
        else if (score_inc && level_q != LEVEL_TOP) level_d = level_q + 3'd1;
    end

    // Frog returns to its start tile when a game begins and on each RESPAWN.
    assign respawn_d = new_game | (state_d == ST_RESPAWN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_ATTRACT;
            start_q   <= 1'b0;
            frame_cnt <= '0;
            lives_q   <= LIVES_LOAD;
            level_q   <= '0;
            speed_q   <= 4'(BASE_SPEED);
            respawn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= bus.start_btn;
            if (state_d != state_q)  frame_cnt <= '0;
            else if (bus.frame_tick) frame_cnt <= frame_cnt + 7'd1;
            if (new_game)            lives_q <= LIVES_LOAD;
            else if (lives_dec)      lives_q <= lives_q - 2'd1;
            level_q   <= level_d;
            // Speed tracks the next level so it changes on entry to LEVEL_UP.
            speed_q   <= 4'(BASE_SPEED) + {1'b0, level_d};
            respawn_q <= respawn_d;
        end
    end

    bcd_counter4 u_score (
        .clk   (clk),
        .reset (reset),
        .clear (new_game),
        .inc   (score_inc),
        .value (score)
    );

`ifdef GAME_CTRL_HISCORE_EN
    // BCD digits order the same as plain binary, so an unsigned compare works.
    logic [15:0] hi_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
        end else if (state_d == ST_GAME_OVER && state_q != ST_GAME_OVER
                     && score > hi_q) begin
            hi_q <= score;
        end
    end
    assign bus.hi_score = hi_q;
`endif

    assign bus.game_state   = state_q;
    assign bus.lives        = lives_q;
    assign bus.level        = level_q;
    assign bus.score        = score;
    assign bus.car_speed    = speed_q;
    assign bus.cars_run     = cars_run_d;
    assign bus.frog_enable  = frog_enable_d;
    assign bus.frog_respawn = respawn_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Randomised scoreboard bench for game_ctrl plus a unit sweep of bcd_counter4.
module tb_game_ctrl;

    localparam int LIVES_INIT = 3, DEATH_FRAMES = 60, WIN_FRAMES = 90;
    localparam int MAX_LEVEL  = 7, BASE_SPEED   = 1;
    localparam int S_ATTRACT = 0, S_PLAY = 1, S_DYING = 2, S_RESPAWN = 3;
    localparam int S_LEVEL_UP = 4, S_GAME_OVER = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    game_ctrl_if bus ();

    game_ctrl #(
        .LIVES_INIT(LIVES_INIT), .DEATH_FRAMES(DEATH_FRAMES), .WIN_FRAMES(WIN_FRAMES),
        .MAX_LEVEL(MAX_LEVEL), .BASE_SPEED(BASE_SPEED)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic        bcd_clear, bcd_inc;
    logic [15:0] bcd_val;
    bcd_counter4 u_bcd (
        .clk   (clk),
        .reset (reset),
        .clear (bcd_clear),
        .inc   (bcd_inc),
        .value (bcd_val)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Reference model: plain integers following the game rules.
    typedef struct {
        int st; int lives; int level; int score; int hi;
        int respawn; int prev_ticks; int prev_cycles;
    } exp_t;
    exp_t q[$];
    int m_state, m_lives, m_level, m_score, m_hi, m_respawns;

    task automatic expect_state(input int st, input int respawn, input int prev_ticks,
                                input int prev_cycles);
        exp_t e;
        m_state       = st;
        e.st          = st;
        e.lives       = m_lives;
        e.level       = m_level;
        e.score       = m_score;
        e.hi          = m_hi;
        e.respawn     = respawn;
        e.prev_ticks  = prev_ticks;
        e.prev_cycles = prev_cycles;
        if (respawn != 0) m_respawns++;
        q.push_back(e);
    endtask

    // Monitor: pops one expectation on every game_state change.
    bit mon_en = 1'b0;
    int prev_st, cyc, tk, rule_bad = 0, respawn_seen = 0;

    always @(negedge clk) begin
        if (!mon_en) begin
            prev_st = int'(bus.game_state);
            cyc     = 0;
            tk      = 0;
        end else begin
            if (bus.frog_respawn) respawn_seen++;
            if (int'(bus.game_state) != S_RESPAWN) begin
                if (bus.frog_enable !== (int'(bus.game_state) == S_PLAY)) rule_bad++;
                if (bus.cars_run !== (int'(bus.game_state) == S_PLAY
                                      || int'(bus.game_state) == S_ATTRACT)) rule_bad++;
            end
            if (int'(bus.game_state) != prev_st) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_transition: %0d -> %0d at %0t",
                             prev_st, bus.game_state, $time);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("game_state", 32'(bus.game_state), e.st);
                    check("lives", 32'(bus.lives), e.lives);
                    check("level", 32'(bus.level), e.level);
                    check("score", 32'(bus.score), 32'(to_bcd(e.score)));
                    check("car_speed", 32'(bus.car_speed), BASE_SPEED + e.level);
                    check("frog_respawn_on_entry", 32'(bus.frog_respawn), e.respawn);
`ifdef GAME_CTRL_HISCORE_EN
                    check("hi_score", 32'(bus.hi_score), 32'(to_bcd(e.hi)));
`endif
                    if (e.prev_ticks >= 0)  check("ticks_in_prev_state", tk, e.prev_ticks);
                    if (e.prev_cycles >= 0) check("cycles_in_prev_state", cyc, e.prev_cycles);
                end
                prev_st = int'(bus.game_state);
                cyc     = 1;
                tk      = int'(bus.frame_tick);
            end else begin
                cyc++;
                tk += int'(bus.frame_tick);
            end
        end
    end

    // Stimulus helpers; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.frog_respawn) begin
            bus.frog_hit  = 1'b0;
            bus.frog_home = 1'b0;
        end
    endtask

    task automatic idle(input int n, input bit ticks);
        repeat (n) begin
            bus.frame_tick = ticks && ($urandom_range(0, 2) == 0);
            step();
        end
        bus.frame_tick = 1'b0;
    endtask

    task automatic run_ticks(input int n, input bit noise);
        for (int k = 0; k < n; k++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin
                bus.start_btn = noise && ($urandom_range(0, 1) == 1);
                step();
            end
            bus.start_btn  = (k != n - 1) && noise && ($urandom_range(0, 1) == 1);
            bus.frame_tick = 1'b1;
            step();
            bus.frame_tick = 1'b0;
        end
        bus.start_btn = 1'b0;
    endtask

    task automatic sync(input string tag);
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: %0d expected transitions not seen", tag, q.size());
            q.delete();
        end
    endtask

    task automatic press();
        bus.start_btn = 1'b0;
        step();
        bus.start_btn = 1'b1;
        if (m_state == S_ATTRACT) begin
            m_lives = LIVES_INIT;
            m_level = 0;
            m_score = 0;
            expect_state(S_PLAY, 1, -1, -1);
        end else if (m_state == S_GAME_OVER) begin
            expect_state(S_ATTRACT, 0, -1, -1);
        end
        step();
        bus.start_btn = 1'b0;
        step();
        sync("press");
    endtask

    task automatic hit(input bit both);
        bus.frog_hit  = 1'b1;
        bus.frog_home = both;
        expect_state(S_DYING, 0, -1, -1);
        m_lives--;
        if (m_lives == 0) begin
            if (m_score > m_hi) m_hi = m_score;
            expect_state(S_GAME_OVER, 0, DEATH_FRAMES, -1);
        end else begin
            expect_state(S_RESPAWN, 1, DEATH_FRAMES, -1);
            expect_state(S_PLAY, 0, -1, 1);
        end
        step();
        run_ticks(DEATH_FRAMES, 1'b1);
        idle(3, 1'b0);
        bus.frog_hit  = 1'b0;
        bus.frog_home = 1'b0;
        sync("hit");
    endtask

    task automatic home();
        bus.frog_home = 1'b1;
        m_score = (m_score < 9999) ? m_score + 1 : 9999;
        m_level = (m_level < MAX_LEVEL) ? m_level + 1 : MAX_LEVEL;
        expect_state(S_LEVEL_UP, 0, -1, -1);
        expect_state(S_RESPAWN, 1, WIN_FRAMES, -1);
        expect_state(S_PLAY, 0, -1, 1);
        step();
        run_ticks(WIN_FRAMES, 1'b1);
        idle(3, 1'b0);
        sync("home");
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_game_state"}, 32'(bus.game_state), S_ATTRACT);
        check({tag, "_lives"}, 32'(bus.lives), LIVES_INIT);
        check({tag, "_level"}, 32'(bus.level), 0);
        check({tag, "_score"}, 32'(bus.score), 0);
        check({tag, "_car_speed"}, 32'(bus.car_speed), BASE_SPEED);
        check({tag, "_cars_run"}, 32'(bus.cars_run), 1);
        check({tag, "_frog_respawn"}, 32'(bus.frog_respawn), 0);
        check({tag, "_frog_enable"}, 32'(bus.frog_enable), 0);
`ifdef GAME_CTRL_HISCORE_EN
        check({tag, "_hi_score"}, 32'(bus.hi_score), 0);
`endif
    endtask

    task automatic model_reset();
        m_state = S_ATTRACT;
        m_lives = LIVES_INIT;
        m_level = 0;
        m_score = 0;
        m_hi    = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        bus.frame_tick = 1'b0;
        bus.start_btn  = 1'b0;
        bus.frog_hit   = 1'b0;
        bus.frog_home  = 1'b0;
        bcd_clear      = 1'b0;
        bcd_inc        = 1'b0;
        m_respawns     = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        reset = 1'b0;
        step();
        mon_en = 1'b1;

        // Directed: start, one hit, eight homes to saturate level, combined event.
        press();
        hit(1'b0);
        for (int i = 0; i < 8; i++) begin
            idle(int'($urandom_range(1, 6)), 1'b1);
            home();
        end
        check("level_saturated", 32'(bus.level), 7);
        check("speed_at_max", 32'(bus.car_speed), 8);
        check("score_after_8", 32'(bus.score), 32'h0008);
        idle(4, 1'b1);
        hit(1'b1);
        hit(1'b0);
        check("lives_at_game_over", 32'(bus.lives), 0);
        press();
        press();
        check("lives_new_game", 32'(bus.lives), 3);

        // Random play across several games.
        repeat (14) begin
            if (m_state == S_GAME_OVER) begin
                press();
                press();
            end else begin
                int r;
                idle(int'($urandom_range(1, 8)), 1'b1);
                r = int'($urandom_range(0, 3));
                if (r < 2)       hit(1'b0);
                else if (r == 2) home();
                else             hit(1'b1);
            end
        end
        if (m_state == S_GAME_OVER) begin
            press();
            press();
        end

        // Asynchronous reset in the middle of DYING.
        bus.frog_hit = 1'b1;
        expect_state(S_DYING, 0, -1, -1);
        step();
        run_ticks(20, 1'b0);
        sync("dying_entry");
        mon_en = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("midreset");
        bus.frog_hit = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step();
        mon_en = 1'b1;
        press();
        hit(1'b0);

        // Unit sweep of the BCD counter through saturation.
        bcd_clear = 1'b1;
        step();
        bcd_clear = 1'b0;
        bcd_inc   = 1'b1;
        for (int n = 1; n <= 10005; n++) begin
            step();
            if (n % 97 == 0 || n >= 9995)
                check("bcd_count", 32'(bcd_val), 32'(to_bcd(n < 9999 ? n : 9999)));
        end
        bcd_inc = 1'b0;
        step();

        idle(4, 1'b0);
        check("scoreboard_drained", q.size(), 0);
        check("respawn_pulse_cycles", respawn_seen, m_respawns);
        check("output_rule_violations", rule_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
